// File: rtl/decode_stage_pipe.sv
// ----------------------------------------------------------------------------
// decode_stage_pipe
//
// Decode stage of the five-stage pipeline, ending in the registered D/X
// pipeline register.
//   - Selects register-file read ports from the F/D instruction. Port A reads
//     rs, or STATUS_REG for bex. Port B reads rt for R-type, and rd otherwise.
//   - Detects load-use hazards against a lw in D/X and inserts one bubble.
//   - Optionally forwards same-cycle writeback data into the captured operands.
//   - Holds D/X on an execute stall and kills it on an execute flush.
//   - Counts hazard bubble cycles in a saturating counter.
//
// Ports
//   i_clock, i_reset_n              rising-edge clock, async active-low reset
//   i_fd_valid/i_fd_insn/i_fd_pc    F/D pipeline register contents
//   o_fd_ready                      decode accepts F/D this cycle (comb)
//   o_ctrl_readRegA/B               register-file read addresses (comb)
//   i_data_readRegA/B               register-file read data
//   i_wb_we/i_wb_addr/i_wb_data     writeback port, same cycle as the RF write
//   i_x_stall, i_x_flush            execute-stage hold / kill requests
//   o_dx_valid/insn/pc/opA/opB      D/X pipeline register (registered)
//   o_stall_count                   saturating load-use bubble counter
// ----------------------------------------------------------------------------
module decode_stage_pipe #(
    parameter int DATA_W     = 32,
    parameter int INSN_W     = 32,
    parameter int REG_AW     = 5,
    parameter int STATUS_REG = 30,
    parameter bit WB_BYPASS  = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_fd_valid,
    input  logic [INSN_W-1:0] i_fd_insn,
    input  logic [DATA_W-1:0] i_fd_pc,
    output logic              o_fd_ready,
    output logic [REG_AW-1:0] o_ctrl_readRegA,
    output logic [REG_AW-1:0] o_ctrl_readRegB,
    input  logic [DATA_W-1:0] i_data_readRegA,
    input  logic [DATA_W-1:0] i_data_readRegB,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_x_stall,
    input  logic              i_x_flush,
    output logic              o_dx_valid,
    output logic [INSN_W-1:0] o_dx_insn,
    output logic [DATA_W-1:0] o_dx_pc,
    output logic [DATA_W-1:0] o_dx_opA,
    output logic [DATA_W-1:0] o_dx_opB,
    output logic [CNT_W-1:0]  o_stall_count
);

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    localparam logic [REG_AW-1:0] STATUS_ADDR = REG_AW'(STATUS_REG);

    // D/X pipeline register
    logic              r_dx_valid;
    logic [INSN_W-1:0] r_dx_insn;
    logic [DATA_W-1:0] r_dx_pc;
    logic [DATA_W-1:0] r_dx_opA;
    logic [DATA_W-1:0] r_dx_opB;
    logic [CNT_W-1:0]  r_stall_count;

    // F/D instruction fields
    logic [4:0]        w_fd_op;
    logic [REG_AW-1:0] w_fd_rd;
    logic [REG_AW-1:0] w_fd_rs;
    logic [REG_AW-1:0] w_fd_rt;
    logic [REG_AW-1:0] w_ra;
    logic [REG_AW-1:0] w_rb;
    logic              w_uses_a;
    logic              w_uses_b;

    // D/X instruction fields used for hazard detection
    logic [4:0]        w_dx_op;
    logic [REG_AW-1:0] w_dx_rd;
    logic              w_hazard;

    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;

    assign w_fd_op = i_fd_insn[INSN_W-1 -: 5];
    assign w_fd_rd = REG_AW'(i_fd_insn[26:22]);
    assign w_fd_rs = REG_AW'(i_fd_insn[21:17]);
    assign w_fd_rt = REG_AW'(i_fd_insn[16:12]);

    assign w_ra = (w_fd_op == OP_BEX) ? STATUS_ADDR : w_fd_rs;
    assign w_rb = (w_fd_op == OP_R)   ? w_fd_rt     : w_fd_rd;

    assign w_uses_a = !((w_fd_op == OP_J) || (w_fd_op == OP_JAL) || (w_fd_op == OP_SETX));
    assign w_uses_b = (w_fd_op == OP_R)   || (w_fd_op == OP_SW) || (w_fd_op == OP_BNE) ||
                      (w_fd_op == OP_BLT) || (w_fd_op == OP_JR);

    assign w_dx_op = r_dx_insn[INSN_W-1 -: 5];
    assign w_dx_rd = REG_AW'(r_dx_insn[26:22]);

    // A lw writing $0 never creates a real dependency, so it must not stall.
    assign w_hazard = i_fd_valid && r_dx_valid && (w_dx_op == OP_LW) && (w_dx_rd != '0) &&
                      ((w_uses_a && (w_dx_rd == w_ra)) || (w_uses_b && (w_dx_rd == w_rb)));

    // Flush wins over everything: the F/D content is discarded anyway, so
    // decode must report itself ready for the redirected fetch.
    assign o_fd_ready = i_x_flush || (!i_x_stall && !w_hazard);

    // Register 0 is hard-wired to zero; otherwise take the writeback value when
    // it targets this port's register in the same cycle the RF is written.
    assign w_op_a = (w_ra == '0) ? '0 :
                    (WB_BYPASS && i_wb_we && (i_wb_addr != '0) && (i_wb_addr == w_ra)) ?
                    i_wb_data : i_data_readRegA;
    assign w_op_b = (w_rb == '0) ? '0 :
                    (WB_BYPASS && i_wb_we && (i_wb_addr != '0) && (i_wb_addr == w_rb)) ?
                    i_wb_data : i_data_readRegB;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_dx_valid    <= 1'b0;
            r_dx_insn     <= '0;
            r_dx_pc       <= '0;
            r_dx_opA      <= '0;
            r_dx_opB      <= '0;
            r_stall_count <= '0;
        end else if (i_x_flush) begin
            r_dx_valid <= 1'b0;
            r_dx_insn  <= '0;
        end else if (i_x_stall) begin
            // Execute is busy: D/X holds, and a pending hazard is not counted.
        end else if (w_hazard) begin
            r_dx_valid <= 1'b0;
            r_dx_insn  <= '0;
            if (r_stall_count != '1) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end else begin
            r_dx_valid <= i_fd_valid;
            r_dx_insn  <= i_fd_insn;
            r_dx_pc    <= i_fd_pc;
            r_dx_opA   <= w_op_a;
            r_dx_opB   <= w_op_b;
        end
    end

    assign o_ctrl_readRegA = w_ra;
    assign o_ctrl_readRegB = w_rb;
    assign o_dx_valid      = r_dx_valid;
    assign o_dx_insn       = r_dx_insn;
    assign o_dx_pc         = r_dx_pc;
    assign o_dx_opA        = r_dx_opA;
    assign o_dx_opB        = r_dx_opB;
    assign o_stall_count   = r_stall_count;

endmodule
